// File: rtl/alu_dot8_unit.sv
// alu_dot8_unit: packed int8 dot-product execute pipe.
// Per lane, four signed byte pairs are multiplied in stage 1 and reduced to
// an 18-bit signed sum in stage 2, sign-extended to XLEN on the commit stream.
// Two elastic stages give one op per cycle with a two-cycle latency.
module alu_dot8_unit #(
   parameter int CORE_ID   = 0,
   parameter int NUM_LANES = 4,
   parameter int XLEN      = 32,
   parameter int UUID_W    = 44,
   parameter int NW_W      = 2,
   parameter int PC_W      = 30,
   parameter int NR_W      = 6,
   parameter int PID_W     = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [UUID_W-1:0]         in_uuid,
   input  logic [NW_W-1:0]           in_wid,
   input  logic [NUM_LANES-1:0]      in_tmask,
   input  logic [PC_W-1:0]           in_PC,
   input  logic [NR_W-1:0]           in_rd,
   input  logic                      in_wb,
   input  logic [PID_W-1:0]          in_pid,
   input  logic                      in_sop,
   input  logic                      in_eop,
   input  logic [NUM_LANES*XLEN-1:0] in_rs1,
   input  logic [NUM_LANES*XLEN-1:0] in_rs2,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [UUID_W-1:0]         out_uuid,
   output logic [NW_W-1:0]           out_wid,
   output logic [NUM_LANES-1:0]      out_tmask,
   output logic [PC_W-1:0]           out_PC,
   output logic [NR_W-1:0]           out_rd,
   output logic                      out_wb,
   output logic [PID_W-1:0]          out_pid,
   output logic                      out_sop,
   output logic                      out_eop,
   output logic [NUM_LANES*XLEN-1:0] out_data
);

   // Sideband that rides unchanged alongside the arithmetic (tmask kept apart,
   // since stage 2 also needs it to zero inactive lanes).
   localparam int SB_W = UUID_W + NW_W + PC_W + NR_W + 1 + PID_W + 1 + 1;

   if (!(XLEN == 32 || XLEN == 64) || CORE_ID < 0) begin : g_bad_cfg
      $error("alu_dot8_unit: XLEN must be 32 or 64 and CORE_ID non-negative");
   end

   // 8x8 signed multiply; both operands widened first so the product is exact.
   function automatic logic signed [15:0] mul8(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
      return 16'(a) * 16'(b);
   endfunction

   // Four-product reduction; 18 bits covers [-65024, +65536] without wrap.
   function automatic logic signed [17:0] sum4(input logic signed [15:0] p0,
                                               input logic signed [15:0] p1,
                                               input logic signed [15:0] p2,
                                               input logic signed [15:0] p3);
      return 18'(p0) + 18'(p1) + 18'(p2) + 18'(p3);
   endfunction

   // Sign-extend the lane sum to XLEN, or force zero for an inactive lane.
   function automatic logic [XLEN-1:0] lane_out(input logic signed [17:0] s,
                                                input logic en);
      return en ? XLEN'(s) : '0;
   endfunction

   logic                      adv1, adv2;
   logic                      vld_p1_q, vld_p2_q;
   logic [SB_W-1:0]           sb_in;
   logic [SB_W-1:0]           sb_p1_q, sb_p2_q;
   logic [NUM_LANES-1:0]      tmask_p1_q, tmask_p2_q;
   logic signed [15:0]        prod_p1_d [NUM_LANES][4];
   logic signed [15:0]        prod_p1_q [NUM_LANES][4];
   logic [NUM_LANES*XLEN-1:0] data_p2_d, data_p2_q;

   assign adv2     = ~vld_p2_q | out_ready;
   assign adv1     = ~vld_p1_q | adv2;
   assign in_ready = adv1 | reset;

   assign sb_in = {in_uuid, in_wid, in_PC, in_rd, in_wb, in_pid, in_sop, in_eop};

   // Stage 1 products: only the low 32 bits of each lane operand are used.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         for (int k = 0; k < 4; k++) begin
            prod_p1_d[i][k] = mul8(in_rs1[i*XLEN + 8*k +: 8], in_rs2[i*XLEN + 8*k +: 8]);
         end
      end
   end

   // Stage 2 reduction and lane masking.
   always_comb begin
      data_p2_d = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         data_p2_d[i*XLEN +: XLEN] = lane_out(sum4(prod_p1_q[i][0], prod_p1_q[i][1],
                                                   prod_p1_q[i][2], prod_p1_q[i][3]),
                                              tmask_p1_q[i]);
      end
   end

   // Stage valid bits: the only reset state; reset drops in-flight ops.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         if (adv1) vld_p1_q <= in_valid;
         if (adv2) vld_p2_q <= vld_p1_q;
      end
   end

   // ---- stage 1 boundary: products and sideband ----
   always_ff @(posedge clk) begin
      if (adv1) begin
         prod_p1_q  <= prod_p1_d;
         sb_p1_q    <= sb_in;
         tmask_p1_q <= in_tmask;
      end
   end

   // ---- stage 2 boundary: sums and sideband, held while stalled ----
   always_ff @(posedge clk) begin
      if (adv2) begin
         data_p2_q  <= data_p2_d;
         sb_p2_q    <= sb_p1_q;
         tmask_p2_q <= tmask_p1_q;
      end
   end

   assign out_valid = vld_p2_q;
   assign out_data  = data_p2_q;
   assign out_tmask = tmask_p2_q;
   assign {out_uuid, out_wid, out_PC, out_rd, out_wb, out_pid, out_sop, out_eop} = sb_p2_q;

endmodule

// File: tb/tb_alu_dot8_unit.sv
// Self-checking bench for alu_dot8_unit: scoreboard of expected results pushed
// on accept and compared in order against captured commits.
module tb_alu_dot8_unit;

   localparam int NL     = 4;
   localparam int XLEN   = 32;
   localparam int UUID_W = 44;
   localparam int NW_W   = 2;
   localparam int PC_W   = 30;
   localparam int NR_W   = 6;
   localparam int PID_W  = 1;
   localparam int DW     = NL * XLEN;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready;
   logic [UUID_W-1:0] in_uuid;
   logic [NW_W-1:0]   in_wid;
   logic [NL-1:0]     in_tmask;
   logic [PC_W-1:0]   in_PC;
   logic [NR_W-1:0]   in_rd;
   logic              in_wb;
   logic [PID_W-1:0]  in_pid;
   logic              in_sop, in_eop;
   logic [DW-1:0]     in_rs1, in_rs2;
   logic              out_valid, out_ready;
   logic [UUID_W-1:0] out_uuid;
   logic [NW_W-1:0]   out_wid;
   logic [NL-1:0]     out_tmask;
   logic [PC_W-1:0]   out_PC;
   logic [NR_W-1:0]   out_rd;
   logic              out_wb;
   logic [PID_W-1:0]  out_pid;
   logic              out_sop, out_eop;
   logic [DW-1:0]     out_data;

   always #5 clk = ~clk;

   alu_dot8_unit #(
      .CORE_ID(0), .NUM_LANES(NL), .XLEN(XLEN), .UUID_W(UUID_W),
      .NW_W(NW_W), .PC_W(PC_W), .NR_W(NR_W), .PID_W(PID_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC),
      .in_rd(in_rd), .in_wb(in_wb), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC),
      .out_rd(out_rd), .out_wb(out_wb), .out_pid(out_pid), .out_sop(out_sop),
      .out_eop(out_eop), .out_data(out_data)
   );

   typedef struct {
      logic [DW-1:0]     data;
      logic [UUID_W-1:0] uuid;
      logic [NW_W-1:0]   wid;
      logic [NL-1:0]     tmask;
      logic [PC_W-1:0]   pc;
      logic [NR_W-1:0]   rd;
      logic              wb;
      logic [PID_W-1:0]  pid;
      logic              sop, eop;
      int                cyc;
   } txn_t;

   txn_t exp_q[$];
   txn_t obs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   n_acc  = 0;

   // Reference dot product: lane sum of signed byte products, zero when masked.
   function automatic logic [DW-1:0] model_dot(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [NL-1:0] m);
      logic [DW-1:0]     r;
      logic signed [7:0] x, y;
      int                s;
      r = '0;
      for (int l = 0; l < NL; l++) begin
         s = 0;
         for (int k = 0; k < 4; k++) begin
            x = a[l*XLEN + 8*k +: 8];
            y = b[l*XLEN + 8*k +: 8];
            s = s + int'(x) * int'(y);
         end
         if (m[l]) r[l*XLEN +: XLEN] = XLEN'(s);
      end
      return r;
   endfunction

   // One clock: record accepts and commits at the falling edge, then step past the rising edge.
   task automatic tick();
      txn_t t;
      @(negedge clk);
      if (in_valid && in_ready && !reset) begin
         t.data = model_dot(in_rs1, in_rs2, in_tmask);
         t.uuid = in_uuid; t.wid = in_wid; t.tmask = in_tmask; t.pc = in_PC;
         t.rd = in_rd; t.wb = in_wb; t.pid = in_pid; t.sop = in_sop; t.eop = in_eop;
         t.cyc = cyc;
         exp_q.push_back(t);
         n_acc++;
      end
      if (out_valid && out_ready) begin
         t.data = out_data;
         t.uuid = out_uuid; t.wid = out_wid; t.tmask = out_tmask; t.pc = out_PC;
         t.rd = out_rd; t.wb = out_wb; t.pid = out_pid; t.sop = out_sop; t.eop = out_eop;
         t.cyc = cyc;
         obs_q.push_back(t);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_op(input logic [UUID_W-1:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic [NL-1:0] m);
      in_valid = 1'b1;
      in_uuid  = u;
      in_rs1   = {NL{a}};
      in_rs2   = {NL{b}};
      in_tmask = m;
      in_wid   = NW_W'($urandom);
      in_PC    = PC_W'($urandom);
      in_rd    = NR_W'($urandom);
      in_wb    = 1'($urandom);
      in_pid   = PID_W'($urandom);
      in_sop   = 1'($urandom);
      in_eop   = 1'($urandom);
   endtask

   task automatic set_rand_op(input logic [UUID_W-1:0] u);
      set_op(u, $urandom, $urandom, NL'($urandom));
      for (int l = 0; l < NL; l++) begin
         in_rs1[l*XLEN +: XLEN] = XLEN'($urandom);
         in_rs2[l*XLEN +: XLEN] = XLEN'($urandom);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_op('0, '0, '0, '0);
      in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_idle: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_basic();
      logic [31:0] ca [4];
      logic [31:0] cb [4];
      logic [31:0] ce [4];
      logic [DW-1:0] want;
      ca = '{32'h01020304, 32'hFFFFFFFF, 32'h80808080, 32'h80808080};
      cb = '{32'h05060708, 32'h7F7F7F7F, 32'h80808080, 32'h7F7F7F7F};
      ce = '{32'h00000046, 32'hFFFFFE04, 32'h00010000, 32'hFFFF0200};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_op(UUID_W'(10 + i), ca[i], cb[i], 4'hF);
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_%0d: out_valid %b want 0 at T+1", i, out_valid);
         end
         tick();
         want = {NL{ce[i]}};
         checks++;
         if (out_valid !== 1'b1 || out_data !== want || out_uuid !== UUID_W'(10 + i)) begin
            errors++;
            $display("FAIL basic_case_%0d: valid %b data %h uuid %0d want 1 %h %0d",
                     i, out_valid, out_data, out_uuid, want, 10 + i);
         end
         tick();
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_tmask();
      logic [DW-1:0] want;
      want = {32'h0, 32'h46, 32'h0, 32'h46};
      out_ready = 1'b1;
      set_op(UUID_W'(20), 32'h01020304, 32'h05060708, 4'b0101);
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== want) begin
         errors++; $display("FAIL tmask_data: valid %b data %h want 1 %h", out_valid, out_data, want);
      end
      checks++;
      if (out_tmask !== 4'b0101) begin
         errors++; $display("FAIL tmask_side: got %b want 0101", out_tmask);
      end
      tick();
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] held;
      txn_t e, o;
      out_ready = 1'b0;
      set_rand_op(UUID_W'(1)); tick();
      set_rand_op(UUID_W'(2)); tick();
      set_rand_op(UUID_W'(3));
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_full: in_ready %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_uuid !== UUID_W'(1)) begin
         errors++; $display("FAIL b2b_head: valid %b uuid %0d want 1 1", out_valid, out_uuid);
      end
      held = out_data;
      tick();
      tick();
      checks++;
      if (out_uuid !== UUID_W'(1) || out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_hold: uuid %0d data %h in_ready %b want 1 %h 0", out_uuid, out_data, in_ready, held);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (obs_q.size() != 3 || exp_q.size() != 3) begin
         errors++; $display("FAIL b2b_count: got %0d outputs %0d accepts want 3 3", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.uuid !== UUID_W'(i + 1) || o.data !== e.data) begin
               errors++; $display("FAIL b2b_order_%0d: uuid %0d data %h want %0d %h", i, o.uuid, o.data, i + 1, e.data);
            end
            if (i > 0) begin
               checks++;
               if (o.cyc != held_cyc(i)) begin
                  errors++; $display("FAIL b2b_gap_%0d: commit cycle %0d want %0d", i, o.cyc, held_cyc(i));
               end
            end
            first_cyc = (i == 0) ? o.cyc : first_cyc;
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   int first_cyc = 0;
   function automatic int held_cyc(input int i);
      return first_cyc + i;
   endfunction

   task automatic test_random();
      localparam int N = 10000;
      int  base, budget, got;
      txn_t e, o;
      base = n_acc; budget = 0; got = 0;
      while ((n_acc - base < N || exp_q.size() > 0) && budget < 60000) begin
         if (n_acc - base < N && ($urandom % 2) == 1) set_rand_op(UUID_W'($urandom) ^ UUID_W'(n_acc));
         else in_valid = 1'b0;
         out_ready = 1'($urandom);
         tick();
         budget++;
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_extra: unexpected output uuid %0d", o.uuid);
            end else begin
               e = exp_q.pop_front();
               if (o.data !== e.data) begin
                  errors++; $display("FAIL rand_data: uuid %0d got %h want %h", e.uuid, o.data, e.data);
               end
               checks++;
               if ({o.uuid, o.wid, o.tmask, o.pc, o.rd, o.wb, o.pid, o.sop, o.eop} !==
                   {e.uuid, e.wid, e.tmask, e.pc, e.rd, e.wb, e.pid, e.sop, e.eop}) begin
                  errors++; $display("FAIL rand_side: got uuid %0d pc %h rd %0d want uuid %0d pc %h rd %0d",
                                     o.uuid, o.pc, o.rd, e.uuid, e.pc, e.rd);
               end
            end
         end
      end
      checks++;
      if (got != N || exp_q.size() != 0) begin
         errors++; $display("FAIL rand_total: got %0d outputs, %0d pending, want %0d and 0", got, exp_q.size(), N);
      end
      in_valid = 1'b0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0;
      set_op(UUID_W'(7), 32'h01020304, 32'h05060708, 4'hF); tick();
      set_op(UUID_W'(8), 32'h01020304, 32'h05060708, 4'hF); tick();
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready);
      end
      tick();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid);
      end
      exp_q.delete(); obs_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (obs_q.size() != 0) begin
         errors++; $display("FAIL flush_ghost: got %0d outputs want 0", obs_q.size());
      end
      set_op(UUID_W'(9), 32'h01020304, 32'h05060708, 4'hF);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_new_early: out_valid %b want 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_uuid !== UUID_W'(9) || out_data !== {NL{32'h00000046}}) begin
         errors++; $display("FAIL flush_new_op: valid %b uuid %0d data %h want 1 9 %h",
                            out_valid, out_uuid, out_data, {NL{32'h00000046}});
      end
      tick();
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tmask();
      test_back_to_back();
      test_random();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
